// File: rtl/mem_access_ctrl.sv
// Sequencer for the multicycle core's unified word memory. It arbitrates the core
// load/store port against the boot-loader write port and handles sub-word accesses.
//
// state | meaning
// IDLE  | sample and arbitrate requests, latch the accepted access
// RD    | word address presented, memory read in flight
// CAP   | read word formatted into core_rdata (load) or merged with store data (SB/SH)
// WR    | single-cycle memory write of the latched or merged word
// DONE  | completion pulse to the granted requester, round-robin pointer update
module mem_access_ctrl #(
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [2:0]        core_funct3,
    input  logic [31:0]       core_addr,
    input  logic [31:0]       core_wdata,
    output logic [31:0]       core_rdata,
    output logic              core_done,
    output logic              core_err,
    input  logic              ldr_req,
    input  logic [31:0]       ldr_addr,
    input  logic [31:0]       ldr_wdata,
    output logic              ldr_done,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [2:0]        state_q, state_d;
    logic [MEM_AW+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              we_q, we_d;
    logic              gnt_core_q, gnt_core_d;
    logic              last_core_q, last_core_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              take_core;
    logic              take_ldr;
    logic              core_bad;

    // Address bits above the memory window wrap; loader byte offset is don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{core_addr[31:MEM_AW+2], ldr_addr[31:MEM_AW+2]};

    function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                             input logic [1:0]  lane,
                                             input logic [31:0] w);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = w >> {lane, 3'b000};
        b       = shifted[7:0];
        h       = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            F3_B:    fmt_load = {{24{b[7]}}, b};
            F3_H:    fmt_load = {{16{h[15]}}, h};
            F3_BU:   fmt_load = {24'h0, b};
            F3_HU:   fmt_load = {16'h0, h};
            default: fmt_load = w;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(input logic [2:0]  f3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] old_w,
                                                input logic [31:0] wd);
        logic [31:0] m;
        m = old_w;
        if (f3 == F3_B) begin
            case (lane)
                2'd0:    m[7:0]   = wd[7:0];
                2'd1:    m[15:8]  = wd[7:0];
                2'd2:    m[23:16] = wd[7:0];
                default: m[31:24] = wd[7:0];
            endcase
        end else if (lane[1]) begin
            m[31:16] = wd[15:0];
        end else begin
            m[15:0] = wd[15:0];
        end
        merge_store = m;
    endfunction

    always_comb begin
        core_bad = 1'b0;
        if (core_we) begin
            case (core_funct3)
                F3_B:    core_bad = 1'b0;
                F3_H:    core_bad = core_addr[0];
                F3_W:    core_bad = |core_addr[1:0];
                default: core_bad = 1'b1;
            endcase
        end else begin
            case (core_funct3)
                F3_B, F3_BU: core_bad = 1'b0;
                F3_H, F3_HU: core_bad = core_addr[0];
                F3_W:        core_bad = |core_addr[1:0];
                default:     core_bad = 1'b1;
            endcase
        end
    end

    // On a tie the requester that did not win last time is served.
    assign take_core = core_req && (!ldr_req || !last_core_q);
    assign take_ldr  = ldr_req && !take_core;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        we_d        = we_q;
        gnt_core_d  = gnt_core_q;
        last_core_d = last_core_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (take_ldr) begin
                    addr_d     = ldr_addr[MEM_AW+1:0];
                    wdata_d    = ldr_wdata;
                    funct3_d   = F3_W;
                    we_d       = 1'b1;
                    gnt_core_d = 1'b0;
                    err_d      = 1'b0;
                    state_d    = S_WR;
                end else if (take_core) begin
                    addr_d     = core_addr[MEM_AW+1:0];
                    wdata_d    = core_wdata;
                    funct3_d   = core_funct3;
                    we_d       = core_we;
                    gnt_core_d = 1'b1;
                    err_d      = core_bad;
                    if (core_bad) begin
                        rdata_d = '0;
                        state_d = S_DONE;
                    end else if (core_we && (core_funct3 == F3_W)) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                if (we_q) begin
                    wdata_d = merge_store(funct3_q, addr_q[1:0], mem_rdata, wdata_q);
                    state_d = S_WR;
                end else begin
                    rdata_d = fmt_load(funct3_q, addr_q[1:0], mem_rdata);
                    state_d = S_DONE;
                end
            end
            S_WR: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                last_core_d = gnt_core_q;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            we_q        <= 1'b0;
            gnt_core_q  <= 1'b0;
            last_core_q <= 1'b1;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            we_q        <= we_d;
            gnt_core_q  <= gnt_core_d;
            last_core_q <= last_core_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    assign core_done  = (state_q == S_DONE) && gnt_core_q;
    assign ldr_done   = (state_q == S_DONE) && !gnt_core_q;
    assign core_err   = core_done && err_q;
    assign core_rdata = rdata_q;
    assign mem_we     = (state_q == S_WR);
    assign mem_addr   = addr_q[MEM_AW+1:2];
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed accesses against a transaction-level model of
// the memory, arbitration and load/store formatting rules.
module tb_mem_access_ctrl;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          core_req = 1'b0, core_we = 1'b0;
    logic [2:0]    core_funct3 = 3'b0;
    logic [31:0]   core_addr = 32'h0, core_wdata = 32'h0;
    logic [31:0]   core_rdata;
    logic          core_done, core_err;
    logic          ldr_req = 1'b0;
    logic [31:0]   ldr_addr = 32'h0, ldr_wdata = 32'h0;
    logic          ldr_done;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we;
    logic [31:0]   mem_rdata;

    logic [31:0]   mem_arr   [0:(1<<AW)-1];
    logic [31:0]   model_mem [0:(1<<AW)-1];

    int            cyc = 0;
    int            n_checks = 0, n_errors = 0;

    int            exp_done_cyc = -1, exp_we_cyc = -1;
    bit            exp_is_core, exp_err, exp_upd;
    logic [31:0]   exp_new_rdata, exp_we_data, exp_rdata_cur;
    int            exp_we_addr;
    bit            model_last_core = 1'b1;
    int            obs_done_cyc = -1, n_core_done = 0, n_ldr_done = 0, n_we = 0;

    mem_access_ctrl #(.MEM_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_funct3(core_funct3),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
        .core_done(core_done), .core_err(core_err),
        .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_done(ldr_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_we) mem_arr[mem_addr] <= mem_wdata;
        mem_rdata <= mem_arr[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * int'(a[1:0]))) & 32'hFF;
        h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? (b | 32'hFFFFFF00) : b;
            3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_merge(input logic [2:0] f3, input logic [31:0] a,
                                                input logic [31:0] w, input logic [31:0] wd);
        logic [31:0] mask, sh;
        if (f3 == 3'd0) begin
            sh   = 8 * int'(a[1:0]);
            mask = 32'hFF << sh;
        end else begin
            sh   = 16 * int'(a[1]);
            mask = 32'hFFFF << sh;
        end
        return (w & ~mask) | ((wd << sh) & mask);
    endfunction

    // Sets up the expected outcome of one accepted access whose IDLE cycle is t0.
    task automatic plan(input bit is_core, input bit we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int t0,
                        output int lat);
        bit bad;
        int w;
        w   = int'(a[AW+1:2]);
        bad = 1'b0;
        if (is_core) begin
            if (we) bad = (f3 >= 3'd3);
            else    bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) bad = 1'b1;
            if (f3 == 3'd2 && a[1:0] != 2'b00) bad = 1'b1;
        end
        exp_is_core   = is_core;
        exp_err       = bad;
        exp_upd       = is_core && (bad || !we);
        exp_we_addr   = w;
        exp_we_cyc    = -1;
        exp_new_rdata = 32'h0;
        if (bad) begin
            lat = 1;
        end else if (!is_core || f3 == 3'd2 && we) begin
            lat         = 2;
            exp_we_cyc  = t0 + 1;
            exp_we_data = wd;
        end else if (!we) begin
            lat           = 3;
            exp_new_rdata = model_load(f3, a, model_mem[w]);
        end else begin
            lat         = 4;
            exp_we_cyc  = t0 + 3;
            exp_we_data = model_merge(f3, a, model_mem[w], wd);
        end
        exp_done_cyc = t0 + lat;
    endtask

    task automatic compare();
        bit ecd, eld, ewe;
        if (!rst_n) exp_rdata_cur = 32'h0;
        ecd = rst_n && (cyc == exp_done_cyc) && exp_is_core;
        eld = rst_n && (cyc == exp_done_cyc) && !exp_is_core;
        ewe = rst_n && (cyc == exp_we_cyc);
        if (ecd && exp_upd) exp_rdata_cur = exp_new_rdata;
        if (core_done || ldr_done) obs_done_cyc = cyc;
        if (core_done) n_core_done++;
        if (ldr_done) n_ldr_done++;
        if (mem_we) n_we++;
        check("core_done", 32'(core_done), 32'(ecd));
        check("ldr_done", 32'(ldr_done), 32'(eld));
        check("core_err", 32'(core_err), 32'(ecd && exp_err));
        check("core_rdata", core_rdata, exp_rdata_cur);
        check("mem_we", 32'(mem_we), 32'(ewe));
        if (ewe) begin
            check("mem_addr", 32'(mem_addr), 32'(exp_we_addr));
            check("mem_wdata", mem_wdata, exp_we_data);
            model_mem[exp_we_addr] = exp_we_data;
        end
    endtask

    task automatic wait_cyc(input int tgt);
        int guard = 0;
        while (cyc < tgt && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("wait_cycle", 32'(cyc), 32'(tgt));
    endtask

    // Called at a negedge of an IDLE cycle; returns at the negedge of the next IDLE cycle.
    task automatic single(input bit is_core, input bit we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, output int t0);
        int lat;
        if (is_core) begin
            core_req = 1'b1; core_we = we; core_funct3 = f3; core_addr = a; core_wdata = wd;
        end else begin
            ldr_req = 1'b1; ldr_addr = a; ldr_wdata = wd;
        end
        t0 = cyc;
        plan(is_core, we, f3, a, wd, t0, lat);
        wait_cyc(t0 + lat);
        core_req = 1'b0;
        ldr_req  = 1'b0;
        model_last_core = is_core;
        @(negedge clk);
    endtask

    initial begin
        int t0, lat, we0, cd0, ld0;
        bit g;
        exp_rdata_cur = 32'h0;
        fork
            forever begin
                @(negedge clk);
                compare();
            end
        join_none

        repeat (3) @(negedge clk);
        #1;
        check("rst_core_done", 32'(core_done), 32'h0);
        check("rst_ldr_done", 32'(ldr_done), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_core_rdata", core_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        single(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, t0);
        check("ldr_latency", 32'(obs_done_cyc - t0), 32'd2);
        check("ldr_word", mem_arr[4], 32'hDEADBEEF);

        single(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, t0);
        check("lw_latency", 32'(obs_done_cyc - t0), 32'd3);
        check("lw_data", core_rdata, 32'hDEADBEEF);

        we0 = n_we;
        single(1'b1, 1'b1, 3'd0, 32'h13, 32'h000000A5, t0);
        check("sb_latency", 32'(obs_done_cyc - t0), 32'd4);
        check("sb_we_cycles", 32'(n_we - we0), 32'd1);
        check("sb_word", mem_arr[4], 32'hA5ADBEEF);

        single(1'b1, 1'b0, 3'd0, 32'h13, 32'h0, t0);
        check("lb_data", core_rdata, 32'hFFFFFFA5);
        single(1'b1, 1'b0, 3'd4, 32'h13, 32'h0, t0);
        check("lbu_data", core_rdata, 32'h000000A5);

        single(1'b1, 1'b1, 3'd1, 32'h12, 32'h00001234, t0);
        check("sh_word", mem_arr[4], 32'h1234BEEF);
        single(1'b1, 1'b0, 3'd1, 32'h10, 32'h0, t0);
        check("lh_data", core_rdata, 32'hFFFFBEEF);
        single(1'b1, 1'b0, 3'd5, 32'h10, 32'h0, t0);
        check("lhu_data", core_rdata, 32'h0000BEEF);

        we0 = n_we;
        single(1'b1, 1'b0, 3'd2, 32'h11, 32'h0, t0);
        check("lw_mis_latency", 32'(obs_done_cyc - t0), 32'd1);
        check("lw_mis_rdata", core_rdata, 32'h0);
        single(1'b1, 1'b0, 3'd3, 32'h10, 32'h0, t0);
        check("ld_ill_latency", 32'(obs_done_cyc - t0), 32'd1);
        single(1'b1, 1'b1, 3'd3, 32'h10, 32'hFFFFFFFF, t0);
        single(1'b1, 1'b1, 3'd1, 32'h11, 32'hFFFFFFFF, t0);
        check("err_no_we", 32'(n_we - we0), 32'h0);
        check("err_mem_kept", mem_arr[4], 32'h1234BEEF);

        cd0 = n_core_done;
        ld0 = n_ldr_done;
        core_req = 1'b1; core_we = 1'b0; core_funct3 = 3'd2; core_addr = 32'h10;
        ldr_req  = 1'b1; ldr_addr = 32'h41; ldr_wdata = 32'hCAFE0001;
        for (int k = 0; k < 4; k++) begin
            g  = !model_last_core;
            t0 = cyc;
            if (g) plan(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, t0, lat);
            else   plan(1'b0, 1'b1, 3'd2, 32'h41, ldr_wdata, t0, lat);
            wait_cyc(t0 + lat);
            model_last_core = g;
            if (k == 3) begin
                core_req = 1'b0;
                ldr_req  = 1'b0;
            end
            @(negedge clk);
        end
        check("rr_core_dones", 32'(n_core_done - cd0), 32'd2);
        check("rr_ldr_dones", 32'(n_ldr_done - ld0), 32'd2);
        check("rr_ldr_word", mem_arr[16], 32'hCAFE0001);
        check("rr_lw_data", core_rdata, 32'h1234BEEF);

        core_req = 1'b1; core_we = 1'b1; core_funct3 = 3'd1;
        core_addr = 32'h12; core_wdata = 32'h00005678;
        t0 = cyc;
        plan(1'b1, 1'b1, 3'd1, 32'h12, 32'h00005678, t0, lat);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_done_cyc = -1;
        exp_we_cyc   = -1;
        model_last_core = 1'b1;
        #1;
        check("abort_mem_we", 32'(mem_we), 32'h0);
        check("abort_core_rdata", core_rdata, 32'h0);
        check("abort_core_done", 32'(core_done), 32'h0);
        check("abort_mem_addr", 32'(mem_addr), 32'h0);
        check("abort_mem_wdata", mem_wdata, 32'h0);
        repeat (2) @(negedge clk);
        check("abort_mem_kept", mem_arr[4], 32'h1234BEEF);
        rst_n = 1'b1;
        t0 = cyc;
        plan(1'b1, 1'b1, 3'd1, 32'h12, 32'h00005678, t0, lat);
        wait_cyc(t0 + lat);
        core_req = 1'b0;
        model_last_core = 1'b1;
        @(negedge clk);
        check("reaccept_latency", 32'(obs_done_cyc - t0), 32'd4);
        check("reaccept_word", mem_arr[4], 32'h5678BEEF);

        single(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, t0);
        check("final_lw", core_rdata, 32'h5678BEEF);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
